memory_stage: RTL

//  MEM stage of the 5-stage RV32 pipeline, directly downstream of execute.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/memory_stage_if.sv | 29 ++
 rtl/memory_stage_data_memory.sv | 26 ++
 rtl/memory_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants: write-back selects, load/store widths, datapath width.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte accesses can sit on any offset; halves need even, words need zero offset.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: is_misaligned = off[0];
      F3_W:        is_misaligned = |off;
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage.
interface memory_stage_if;
  import riscv_pkg::*;

  logic            regwriteM;
  logic            memrwM;
  logic [1:0]      wbselM;
  logic [2:0]      funct3M;
  logic [4:0]      rdM;
  logic [XLEN-1:0] ALUresM;
  logic [XLEN-1:0] data_writeM;
  logic [XLEN-1:0] pc4M;

  logic            regwriteW;
  logic [4:0]      rdW;
  logic [XLEN-1:0] resultW;
  logic            misalignW;

  modport master (
    output regwriteM, memrwM, wbselM, funct3M, rdM, ALUresM, data_writeM, pc4M,
    input  regwriteW, rdW, resultW, misalignW
  );

  modport slave (
    input  regwriteM, memrwM, wbselM, funct3M, rdM, ALUresM, data_writeM, pc4M,
    output regwriteW, rdW, resultW, misalignW
  );

endinterface

// File: rtl/memory_stage_data_memory.sv
// Word-organised data memory with per-byte write enables and asynchronous read.
module data_memory #(
  parameter int DMEM_WORDS = 1024,
  parameter int AW         = $clog2(DMEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DMEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// RV32 MEM stage: alignment/range check, byte-lane stores, load extraction,
// MEM/WB register and write-back mux.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int DMEM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  memory_stage_if.slave bus
);

  localparam int              AW         = $clog2(DMEM_WORDS);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * DMEM_WORDS);

  logic [1:0]      off;
  logic            access, fault, we;
  logic [3:0]      be;
  logic [31:0]     wdata, rdata, shifted;
  logic [XLEN-1:0] load_val;

  logic            regwrite_q, regwrite_d;
  logic [4:0]      rd_q, rd_d;
  logic            misalign_q, misalign_d;
  logic [1:0]      wbsel_q, wbsel_d;
  logic [XLEN-1:0] alu_q, alu_d, load_q, load_d, pc4_q, pc4_d;

  assign off    = bus.ALUresM[1:0];
  assign access = bus.memrwM | (bus.wbselM == WB_MEM);
  // High address bits are never aliased onto the array: anything past the end faults.
  assign fault  = access & (is_misaligned(bus.funct3M, off) | (bus.ALUresM >= ADDR_LIMIT));
  assign we     = bus.memrwM & ~fault & rst_n & (|be);

  always_comb begin
    be    = 4'b0000;
    wdata = bus.data_writeM;
    case (bus.funct3M)
      F3_B: begin
        be    = 4'b0001 << off;
        wdata = {4{bus.data_writeM[7:0]}};
      end
      F3_H: begin
        be    = 4'b0011 << off;
        wdata = {2{bus.data_writeM[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  data_memory #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
    .clk   (clk),
    .addr  (bus.ALUresM[AW+1:2]),
    .we    (we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    load_val = '0;
    if (!fault) begin
      case (bus.funct3M)
        F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
        F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
        F3_W:    load_val = rdata;
        F3_BU:   load_val = {24'd0, shifted[7:0]};
        F3_HU:   load_val = {16'd0, shifted[15:0]};
        default: load_val = '0;
      endcase
    end
  end

  always_comb begin
    regwrite_d = bus.regwriteM & ~fault;
    rd_d       = bus.rdM;
    misalign_d = fault;
    wbsel_d    = bus.wbselM;
    alu_d      = bus.ALUresM;
    load_d     = load_val;
    pc4_d      = bus.pc4M;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      misalign_q <= 1'b0;
      wbsel_q    <= WB_ALU;
      alu_q      <= '0;
      load_q     <= '0;
      pc4_q      <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
      wbsel_q    <= wbsel_d;
      alu_q      <= alu_d;
      load_q     <= load_d;
      pc4_q      <= pc4_d;
    end
  end

  assign bus.regwriteW = regwrite_q;
  assign bus.rdW       = rd_q;
  assign bus.misalignW = misalign_q;

  always_comb begin
    case (wbsel_q)
      WB_ALU:  bus.resultW = alu_q;
      WB_MEM:  bus.resultW = load_q;
      WB_PC4:  bus.resultW = pc4_q;
      default: bus.resultW = '0;
    endcase
  end

endmodule
